// File: rtl/sim_run_ctrl.sv
// ============================================================================
// Module   : sim_run_ctrl
// Brief    : Staggered per-channel reset sequencer with run/done/watchdog
//            tracking. Optional watchdog enabled by SIM_RUN_CTRL_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_run_ctrl #(
  parameter int RST_CYCLES = 25,
  parameter int NUM_CH     = 2,
  parameter int STAGGER    = 4,
  parameter int TIMEOUT    = 5000,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_rst_req,
  input  logic              halt_i,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              run_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              done_o,
  output logic              timeout_o
);

  // Edge index (since HOLD entry) of the last channel release.
  localparam int c_last_rel = RST_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int c_seq_w    = $clog2(c_last_rel + 2);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
`ifdef SIM_RUN_CTRL_WDOG_EN
  localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);
`endif

  generate
    if (RST_CYCLES < 1) begin : g_chk_rst_cycles
      $error("sim_run_ctrl: RST_CYCLES must be >= 1");
    end
    if (NUM_CH < 1) begin : g_chk_num_ch
      $error("sim_run_ctrl: NUM_CH must be >= 1");
    end
    if (STAGGER < 1) begin : g_chk_stagger
      $error("sim_run_ctrl: STAGGER must be >= 1");
    end
    if (TIMEOUT < 1 || (CNT_W < 31 && TIMEOUT >= (1 << CNT_W))) begin : g_chk_timeout
      $error("sim_run_ctrl: TIMEOUT out of range for CNT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_STAGE   = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3
`ifdef SIM_RUN_CTRL_WDOG_EN
    ,S_TIMEOUT = 3'd4
`endif
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_seq_w-1:0]  r_seq;
  logic [c_seq_w-1:0]  w_seq_nxt;
  logic [c_seq_w-1:0]  w_seq_inc;
  logic [NUM_CH-1:0]   r_ch_rst;
  logic [NUM_CH-1:0]   w_ch_rst_nxt;
  logic                r_run;
  logic                w_run_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_done;
  logic                w_done_nxt;
`ifdef SIM_RUN_CTRL_WDOG_EN
  logic                r_to;
  logic                w_to_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_HOLD;
      r_seq    <= '0;
      r_ch_rst <= '1;
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
`ifdef SIM_RUN_CTRL_WDOG_EN
      r_to     <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_seq    <= w_seq_nxt;
      r_ch_rst <= w_ch_rst_nxt;
      r_run    <= w_run_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_done_nxt;
`ifdef SIM_RUN_CTRL_WDOG_EN
      r_to     <= w_to_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_seq_nxt    = r_seq;
    w_ch_rst_nxt = r_ch_rst;
    w_run_nxt    = r_run;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = r_done;
`ifdef SIM_RUN_CTRL_WDOG_EN
    w_to_nxt     = r_to;
`endif
    w_seq_inc    = r_seq + 1'b1;

    if (ext_rst_req) begin
      w_state_nxt  = S_HOLD;
      w_seq_nxt    = '0;
      w_ch_rst_nxt = '1;
      w_run_nxt    = 1'b0;
      w_cnt_nxt    = '0;
      w_done_nxt   = 1'b0;
`ifdef SIM_RUN_CTRL_WDOG_EN
      w_to_nxt     = 1'b0;
`endif
    end else begin
      case (r_state)
        S_HOLD, S_STAGE: begin
          w_seq_nxt = w_seq_inc;
          // A channel drops on the edge whose index matches its release slot.
          for (int k = 0; k < NUM_CH; k++) begin
            if (w_seq_inc == c_seq_w'(RST_CYCLES + k * STAGGER)) begin
              w_ch_rst_nxt[k] = 1'b0;
            end
          end
          if (r_state == S_HOLD && w_seq_inc == c_seq_w'(RST_CYCLES)) begin
            w_state_nxt = S_STAGE;
          end
          if (r_state == S_STAGE && w_seq_inc == c_seq_w'(c_last_rel + 1)) begin
            w_state_nxt = S_RUN;
            w_seq_nxt   = '0;
            w_run_nxt   = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
        S_RUN: begin
          if (halt_i) begin
            w_state_nxt = S_DONE;
            w_run_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
          end
`ifdef SIM_RUN_CTRL_WDOG_EN
          else if (r_cnt == c_to_last) begin
            w_state_nxt = S_TIMEOUT;
            w_run_nxt   = 1'b0;
            w_to_nxt    = 1'b1;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
`endif
          else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DONE: begin
        end
`ifdef SIM_RUN_CTRL_WDOG_EN
        S_TIMEOUT: begin
        end
`endif
        default: begin
          w_state_nxt  = S_HOLD;
          w_seq_nxt    = '0;
          w_ch_rst_nxt = '1;
          w_run_nxt    = 1'b0;
          w_cnt_nxt    = '0;
          w_done_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign ch_rst_o    = r_ch_rst;
  assign run_o       = r_run;
  assign cycle_cnt_o = r_cnt;
  assign done_o      = r_done;
`ifdef SIM_RUN_CTRL_WDOG_EN
  assign timeout_o   = r_to;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
// ============================================================================
// Module   : tb_sim_run_ctrl
// Brief    : Directed self-checking bench for sim_run_ctrl (default instance
//            plus a narrow 4-channel instance with a 4-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ext_rst_req;
  logic        halt_i;
  logic [1:0]  d_ch;
  logic        d_run;
  logic [31:0] d_cnt;
  logic        d_done;
  logic        d_to;

  logic        s_ext;
  logic        s_halt;
  logic [3:0]  s_ch;
  logic        s_run;
  logic [3:0]  s_cnt;
  logic        s_done;
  logic        s_to;

  int n_err;
  int n_chk;

  sim_run_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ext_rst_req (ext_rst_req),
    .halt_i      (halt_i),
    .ch_rst_o    (d_ch),
    .run_o       (d_run),
    .cycle_cnt_o (d_cnt),
    .done_o      (d_done),
    .timeout_o   (d_to)
  );

  sim_run_ctrl #(
    .RST_CYCLES (1),
    .NUM_CH     (4),
    .STAGGER    (1),
    .TIMEOUT    (10),
    .CNT_W      (4)
  ) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .ext_rst_req (s_ext),
    .halt_i      (s_halt),
    .ch_rst_o    (s_ch),
    .run_o       (s_run),
    .cycle_cnt_o (s_cnt),
    .done_o      (s_done),
    .timeout_o   (s_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    rst_n = 1'b0;
    ext_rst_req = 1'b0;
    halt_i = 1'b0;
    s_ext = 1'b0;
    s_halt = 1'b0;

    // Reset state of both instances
    step(3);
    chk("rst_d_ch", d_ch, 2'b11);
    chk("rst_d_run", d_run, 0);
    chk("rst_d_cnt", d_cnt, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_d_to", d_to, 0);
    chk("rst_s_ch", s_ch, 4'b1111);

    // Release; edge 1 is the next rising edge
    rst_n = 1'b1;
    step(1); chk("s_e1_ch", s_ch, 4'b1110);
    step(1); chk("s_e2_ch", s_ch, 4'b1100);
    step(1); chk("s_e3_ch", s_ch, 4'b1000);
    step(1); chk("s_e4_ch", s_ch, 4'b0000);
             chk("s_e4_run", s_run, 0);
    step(1); chk("s_e5_run", s_run, 1);
             chk("s_e5_cnt", s_cnt, 0);
    step(19);
    chk("d_e24_ch", d_ch, 2'b11);
`ifdef SIM_RUN_CTRL_WDOG_EN
    chk("s_e24_cnt_to", s_cnt, 10);
    chk("s_e24_to", s_to, 1);
    chk("s_e24_run", s_run, 0);
`else
    chk("s_e24_cnt_sat", s_cnt, 15);
    chk("s_e24_to", s_to, 0);
    chk("s_e24_run", s_run, 1);
`endif
    step(1); chk("d_e25_ch", d_ch, 2'b10);
             chk("d_e25_run", d_run, 0);
    step(3); chk("d_e28_ch", d_ch, 2'b10);
    step(1); chk("d_e29_ch", d_ch, 2'b00);
             chk("d_e29_run", d_run, 0);
    step(1); chk("d_e30_run", d_run, 1);
             chk("d_e30_cnt", d_cnt, 0);

    // Halt at cycle count 100
    step(100); chk("d_cnt100", d_cnt, 100);
    halt_i = 1'b1;
    step(1);
    halt_i = 1'b0;
    chk("d_halt_done", d_done, 1);
    chk("d_halt_run", d_run, 0);
    chk("d_halt_cnt", d_cnt, 100);
    chk("d_halt_to", d_to, 0);
    step(5);
    halt_i = 1'b1;
    step(1);
    halt_i = 1'b0;
    step(3);
    chk("d_sticky_done", d_done, 1);
    chk("d_sticky_cnt", d_cnt, 100);
    chk("d_sticky_run", d_run, 0);

    // Narrow instance: held restart, then halt on the watchdog edge
    s_ext = 1'b1;
    step(3);
    chk("s_ext_ch", s_ch, 4'b1111);
    chk("s_ext_run", s_run, 0);
    chk("s_ext_cnt", s_cnt, 0);
    chk("s_ext_to", s_to, 0);
    s_ext = 1'b0;
    step(1); chk("s_r1_ch", s_ch, 4'b1110);
    step(3); chk("s_r4_ch", s_ch, 4'b0000);
    step(1); chk("s_r5_run", s_run, 1);
             chk("s_r5_cnt", s_cnt, 0);
    step(9); chk("s_r14_cnt", s_cnt, 9);
    s_halt = 1'b1;
    step(1);
    s_halt = 1'b0;
    chk("s_tie_done", s_done, 1);
    chk("s_tie_to", s_to, 0);
    chk("s_tie_cnt", s_cnt, 9);
    chk("s_tie_run", s_run, 0);

    // Restart request from DONE
    ext_rst_req = 1'b1;
    step(1);
    ext_rst_req = 1'b0;
    chk("d_ext_ch", d_ch, 2'b11);
    chk("d_ext_done", d_done, 0);
    chk("d_ext_cnt", d_cnt, 0);
    chk("d_ext_run", d_run, 0);
    step(24); chk("d_x24_ch", d_ch, 2'b11);
    step(1);  chk("d_x25_ch", d_ch, 2'b10);
    step(2);  chk("d_x27_ch", d_ch, 2'b10);

    // Asynchronous reset mid-STAGE
    rst_n = 1'b0;
    #1;
    chk("d_async_ch", d_ch, 2'b11);
    chk("d_async_run", d_run, 0);
    chk("s_async_ch", s_ch, 4'b1111);
    chk("s_async_done", s_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(24); chk("d_y24_ch", d_ch, 2'b11);
    step(1);  chk("d_y25_ch", d_ch, 2'b10);
    step(4);  chk("d_y29_ch", d_ch, 2'b00);
              chk("d_y29_run", d_run, 0);
    step(1);  chk("d_y30_run", d_run, 1);
              chk("d_y30_cnt", d_cnt, 0);

`ifdef SIM_RUN_CTRL_WDOG_EN
    // Watchdog expiry on the default instance
    step(4999); chk("d_wd_cnt4999", d_cnt, 4999);
                chk("d_wd_run_pre", d_run, 1);
    step(1);    chk("d_wd_to", d_to, 1);
                chk("d_wd_cnt", d_cnt, 5000);
                chk("d_wd_run", d_run, 0);
                chk("d_wd_done", d_done, 0);
    halt_i = 1'b1;
    step(1);
    halt_i = 1'b0;
    chk("d_wd_sticky_to", d_to, 1);
    chk("d_wd_sticky_done", d_done, 0);
`else
    step(200);
    chk("d_run_cnt200", d_cnt, 200);
    chk("d_run_to", d_to, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
